// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard port: receiver states, bus offsets, status layout.
// Pure declarations, no timing of its own.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [31:0] OFF_DATA = 32'h0000_0000;
  localparam logic [31:0] OFF_STAT = 32'h0000_0004;

  localparam int STAT_READY = 0;
  localparam int STAT_PERR  = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_FULL  = 3;

  // Field order matches the STAT_* bit positions above (MSB first).
  typedef struct packed {
    logic full;
    logic ovf;
    logic perr;
    logic ready;
  } stat_t;

  // True when the 8 data bits plus the parity bit hold an odd number of ones.
  function automatic logic odd_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Scancode FIFO: push/pop take effect on the clock edge, count/full/empty registered, dout shows head combinationally.
// A push when full is dropped unless a pop happens on the same edge; a pop when empty is ignored.
module ps2_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_kbd_port.sv
// PS/2 keyboard receiver with scancode FIFO and a two-register read bus; byte lands in FIFO on the stop-bit edge (3 clk after ps2_clk falls).
// No backpressure toward the keyboard: bytes arriving while the FIFO is full are dropped and flagged as overflow.
module ps2_kbd_port
  import ps2_pkg::*;
#(
  parameter int          DEPTH   = 8,
  parameter int          TIMEOUT = 5000,
  parameter logic [31:0] BASE    = 32'hD000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic [31:0] addr,
  input  logic        rd,
  output logic [31:0] dataOut,
  output logic        ready,
  output logic        irq
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          r_clk_meta, r_clk_sync, r_clk_prev;
  logic          r_dat_meta, r_dat_sync;
  ps2_state_t    r_state, w_next;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_tmo;
  logic          r_ovf, r_perr;

  logic          w_fall, w_timeout;
  logic          w_shift, w_par_ld, w_push, w_perr_set;
  logic          w_rd_data, w_rd_stat, w_pop, w_ovf_set;
  logic [7:0]    w_head;
  logic [CW-1:0] w_count;
  logic          w_full, w_empty;
  stat_t         w_stat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= ps2_clk;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
      r_dat_meta <= ps2_data;
      r_dat_sync <= r_dat_meta;
    end
  end

  assign w_fall    = r_clk_prev & ~r_clk_sync;
  // A falling edge on the same cycle rescues the frame from timing out.
  assign w_timeout = (r_state != IDLE) && !w_fall && (r_tmo == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_shift    = 1'b0;
    w_par_ld   = 1'b0;
    w_push     = 1'b0;
    w_perr_set = 1'b0;
    if (w_timeout) begin
      w_next = IDLE;
    end else if (w_fall) begin
      case (r_state)
        IDLE:   if (!r_dat_sync) w_next = DATA;
        DATA: begin
          w_shift = 1'b1;
          if (r_bitcnt == 3'd7) w_next = PARITY;
        end
        PARITY: begin
          w_par_ld = 1'b1;
          w_next   = STOP;
        end
        STOP: begin
          w_next = IDLE;
          if (r_dat_sync && odd_ok(r_shift, r_par)) w_push = 1'b1;
          else                                      w_perr_set = 1'b1;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_tmo    <= '0;
    end else begin
      if (w_fall || r_state == IDLE || w_timeout) r_tmo <= '0;
      else                                        r_tmo <= r_tmo + TW'(1);

      if (w_timeout || (w_fall && r_state == IDLE)) r_bitcnt <= '0;
      else if (w_shift)                             r_bitcnt <= r_bitcnt + 3'd1;

      if (w_timeout)    r_shift <= '0;
      else if (w_shift) r_shift <= {r_dat_sync, r_shift[7:1]};

      if (w_par_ld) r_par <= r_dat_sync;
    end
  end

  assign w_rd_data = rd && (addr == BASE + OFF_DATA);
  assign w_rd_stat = rd && (addr == BASE + OFF_STAT);
  assign w_pop     = w_rd_data & ~w_empty;
  assign w_ovf_set = w_push & w_full & ~w_pop;

  ps2_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (r_shift),
    .dout  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // Setting a flag outranks the clear-on-read of the status register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf  <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      r_ovf  <= w_ovf_set  | (r_ovf  & ~w_rd_stat);
      r_perr <= w_perr_set | (r_perr & ~w_rd_stat);
    end
  end

  assign ready  = (w_count != '0);
  assign irq    = ready | r_ovf | r_perr;
  assign w_stat = {w_full, r_ovf, r_perr, ready};

  always_comb begin
    dataOut = 32'h0;
    if (addr == BASE + OFF_DATA) begin
      if (!w_empty) dataOut = {23'b0, 1'b1, w_head};
    end else if (addr == BASE + OFF_STAT) begin
      dataOut = {28'b0, w_stat};
    end
  end

endmodule

// File: tb/tb_ps2_kbd_port.sv
// Bench for ps2_kbd_port: directed scenarios with literal expectations plus randomized frames,
// all checked every cycle against a frame-level model of the port.
module tb_ps2_kbd_port;

  localparam int          DEPTH   = 8;
  localparam int          TIMEOUT = 5000;
  localparam logic [31:0] BASE    = 32'hD000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] addr = BASE;
  logic        rd = 1'b0;
  logic [31:0] dataOut;
  logic        ready;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  ps2_kbd_port #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .BASE(BASE)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .addr     (addr),
    .rd       (rd),
    .dataOut  (dataOut),
    .ready    (ready),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Line samples are seen by the receiver two clocks late; an edge is acted on one clock after that.
  logic [7:0] q[$];
  bit         m_ovf, m_perr;
  int         pos;        // 0 idle, 1..8 data bit index+1, 9 parity, 10 stop
  bit [7:0]   m_byte;
  bit         m_par;
  int         quiet;
  bit         c_m, c_s, c_p, d_m, d_s;

  always @(posedge clk or negedge reset) begin : model
    bit fall, d, push_ev, perr_ev, ovf_ev, pop_ev, stat_rd, accept;
    if (!reset) begin
      q.delete();
      m_ovf = 0; m_perr = 0; pos = 0; m_byte = 0; m_par = 0; quiet = 0;
      c_m = 1; c_s = 1; c_p = 1; d_m = 1; d_s = 1;
    end else begin
      fall = c_p && !c_s;
      d    = d_s;
      push_ev = 0; perr_ev = 0; ovf_ev = 0;
      if (fall) begin
        quiet = 0;
        if (pos == 0) begin
          if (!d) pos = 1;
        end else if (pos <= 8) begin
          m_byte[pos-1] = d;
          pos++;
        end else if (pos == 9) begin
          m_par = d;
          pos = 10;
        end else begin
          if (d && (^{m_byte, m_par})) push_ev = 1;
          else                         perr_ev = 1;
          pos = 0;
        end
      end else if (pos != 0) begin
        quiet++;
        if (quiet >= TIMEOUT) begin
          pos = 0;
          quiet = 0;
        end
      end
      pop_ev  = rd && addr == BASE && q.size() > 0;
      stat_rd = rd && addr == BASE + 4;
      accept  = push_ev && (q.size() < DEPTH || pop_ev);
      if (push_ev && !accept) ovf_ev = 1;
      if (pop_ev) void'(q.pop_front());
      if (accept) q.push_back(m_byte);
      m_ovf  = ovf_ev  || (m_ovf  && !stat_rd);
      m_perr = perr_ev || (m_perr && !stat_rd);
      c_p = c_s; c_s = c_m; c_m = ps2_clk;
      d_s = d_m; d_m = ps2_data;
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] e;
    e = 32'h0;
    if (addr == BASE && q.size() > 0)
      e = {23'b0, 1'b1, q[0]};
    else if (addr == BASE + 4)
      e = {28'b0, q.size() == DEPTH, m_ovf, m_perr, q.size() > 0};
    chk("dataOut", dataOut, e);
    chk("ready", ready, q.size() > 0);
    chk("irq", irq, (q.size() > 0) || m_ovf || m_perr);
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ps2_bit(input logic d, input int half, input bit pop_mid);
    ps2_data = d;
    tick(half);
    ps2_clk = 1'b0;
    if (pop_mid) begin
      // Line the read up with the edge on which the stop bit pushes.
      tick(2);
      addr = BASE;
      rd   = 1'b1;
      tick(1);
      rd   = 1'b0;
      tick(half - 3);
    end else begin
      tick(half);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop,
                            input int half, input int nbits, input bit pop_on_stop);
    logic bits [11];
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    bits[9]  = (~^b) ^ bad_par;
    bits[10] = stop;
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i], half, pop_on_stop && i == 10);
    ps2_data = 1'b1;
  endtask

  task automatic good_frame(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 5, 11, 1'b0);
    tick(4);
  endtask

  task automatic rd_bus(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    rd   = 1'b1;
    #1 v = dataOut;
    tick(1);
    rd   = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation ran past its time budget");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] v;
    tick(3);
    chk("reset ready", ready, 0);
    chk("reset irq", irq, 0);
    chk("reset data", dataOut, 32'h0);
    addr = BASE + 4;
    #1 chk("reset status", dataOut, 32'h0);
    reset = 1'b1;
    tick(3);

    // Clean 8'h1C frame.
    good_frame(8'h1C);
    chk("1C ready", ready, 1);
    rd_bus(BASE, v);
    chk("1C data", v, 32'h0000_011C);
    chk("1C ready after pop", ready, 0);

    // Parity error.
    send_frame(8'h1C, 1'b1, 1'b1, 5, 11, 1'b0);
    tick(4);
    chk("perr ready", ready, 0);
    rd_bus(BASE + 4, v);
    chk("perr status", v, 32'h2);
    rd_bus(BASE + 4, v);
    chk("perr cleared", v, 32'h0);

    // Nine frames into an eight-entry FIFO.
    for (int i = 1; i <= 9; i++) good_frame(8'(i));
    rd_bus(BASE + 4, v);
    chk("ovf status", v, 32'hD);
    for (int i = 1; i <= 8; i++) begin
      rd_bus(BASE, v);
      chk("ovf order", v, 32'h100 | i);
    end

    // Partial frame abandoned by timeout.
    send_frame(8'hA5, 1'b0, 1'b1, 5, 4, 1'b0);
    tick(TIMEOUT + 10);
    good_frame(8'h1C);
    rd_bus(BASE + 4, v);
    chk("timeout status", v, 32'h1);
    rd_bus(BASE, v);
    chk("timeout data", v, 32'h0000_011C);
    rd_bus(BASE + 4, v);
    chk("timeout empty", v, 32'h0);

    // Full FIFO, pop on the push edge of 8'h55.
    for (int i = 0; i < 8; i++) good_frame(8'h30 + 8'(i));
    send_frame(8'h55, 1'b0, 1'b1, 5, 11, 1'b1);
    tick(4);
    rd_bus(BASE + 4, v);
    chk("pushpop status", v, 32'h9);
    for (int i = 1; i < 8; i++) begin
      rd_bus(BASE, v);
      chk("pushpop order", v, 32'h130 + i);
    end
    rd_bus(BASE, v);
    chk("pushpop last", v, 32'h0000_0155);

    // Reset in the middle of a frame.
    send_frame(8'h77, 1'b0, 1'b1, 5, 6, 1'b0);
    reset = 1'b0;
    tick(3);
    chk("midreset ready", ready, 0);
    reset = 1'b1;
    tick(3);
    good_frame(8'h1C);
    rd_bus(BASE + 4, v);
    chk("midreset status", v, 32'h1);
    rd_bus(BASE, v);
    chk("midreset data", v, 32'h0000_011C);

    // Randomized traffic, checked by the model only.
    for (int f = 0; f < 40; f++) begin
      int err, half, nrd;
      logic [7:0] b;
      b    = 8'($urandom);
      err  = $urandom_range(0, 7);
      half = $urandom_range(3, 7);
      send_frame(b, err == 0, err != 1, half, 11, $urandom_range(0, 3) == 0);
      tick($urandom_range(0, 10));
      nrd = $urandom_range(0, 2);
      for (int r = 0; r < nrd; r++) begin
        case ($urandom_range(0, 3))
          0, 1:    rd_bus(BASE, v);
          2:       rd_bus(BASE + 4, v);
          default: rd_bus(BASE + 8, v);
        endcase
      end
    end
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
